// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Instruction-fetch halfword queue with RVC/32-bit issue.
//            Fetches one 32-bit word per cycle from a combinational
//            instruction memory into a circular halfword queue, then issues
//            one RVC (16-bit) or 32-bit instruction per cycle into the
//            IF pipeline register. Supports EX flush redirect, issue stall
//            and predicted-taken redirect.
// Ports    : clk, rstn (async active-low)
//            flush_IF, pc_nxt_EX    - EX redirect
//            stall_IF               - hold issue stage
//            predict, predict_pc    - predictor result for pc_head
//            imem_addr, imem_rdata  - instruction memory word port
//            pc_head                - PC of queue head instruction
//            ir_IF, pc_IF, pc_4_IF, rvc_IF, predict_IF, valid_IF - issue reg
//            q_count                - occupied halfwords
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h3000,
  parameter int          DEPTH    = 8,
  parameter int          IMEM_AW  = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush_IF,
  input  logic                     stall_IF,
  input  logic [31:0]              pc_nxt_EX,
  input  logic                     predict,
  input  logic [31:0]              predict_pc,
  output logic [IMEM_AW-1:0]       imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              pc_head,
  output logic [31:0]              ir_IF,
  output logic [31:0]              pc_IF,
  output logic [31:0]              pc_4_IF,
  output logic                     rvc_IF,
  output logic                     predict_IF,
  output logic                     valid_IF,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int          c_PW  = $clog2(DEPTH);
  localparam int          c_CW  = c_PW + 1;
  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic [15:0]     r_q [DEPTH];
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_CW-1:0] r_count;
  logic [31:0]     r_fetch_pc;
  logic            r_skip_lo;
  logic [31:0]     r_pc_head;

  logic [15:0]     w_h0;
  logic [15:0]     w_h1;
  logic [c_PW-1:0] w_head_p1;
  logic [c_PW-1:0] w_tail_p1;
  logic            w_rvc;
  logic            w_avail;
  logic            w_issue;
  logic            w_redirect;
  logic            w_can_push;
  logic [c_CW-1:0] w_free;
  logic [c_CW-1:0] w_pushed;
  logic [c_CW-1:0] w_popped;
  logic [31:0]     w_ilen;

  assign w_head_p1 = r_head + c_PW'(1);
  assign w_tail_p1 = r_tail + c_PW'(1);
  assign w_h0      = r_q[r_head];
  assign w_h1      = r_q[w_head_p1];
  assign w_rvc     = (w_h0[1:0] != 2'b11);
  assign w_avail   = w_rvc ? (r_count != '0) : (r_count >= c_CW'(2));
  assign w_issue   = w_avail && !stall_IF && !flush_IF;
  // A taken prediction only counts when the predicted instruction issues.
  assign w_redirect = w_issue && predict;

  // Room is judged on the current count, before this cycle's pop.
  assign w_free     = c_CW'(DEPTH) - r_count;
  assign w_can_push = (w_free >= c_CW'(2));
  assign w_pushed   = w_can_push ? (r_skip_lo ? c_CW'(1) : c_CW'(2)) : '0;
  assign w_popped   = w_issue ? (w_rvc ? c_CW'(1) : c_CW'(2)) : '0;
  assign w_ilen     = w_rvc ? 32'd2 : 32'd4;

  assign imem_addr = r_fetch_pc[IMEM_AW+1:2];
  assign pc_head   = r_pc_head;
  assign q_count   = r_count;

  // Queue storage: no reset needed, occupancy is tracked by pointers/count.
  always_ff @(posedge clk) begin
    if (w_can_push && !flush_IF && !w_redirect) begin
      if (r_skip_lo) begin
        r_q[r_tail] <= imem_rdata[31:16];
      end else begin
        r_q[r_tail]    <= imem_rdata[15:0];
        r_q[w_tail_p1] <= imem_rdata[31:16];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fetch_pc <= {RESET_PC[31:2], 2'b00};
      r_skip_lo  <= RESET_PC[1];
      r_pc_head  <= RESET_PC;
      ir_IF      <= c_NOP;
      pc_IF      <= '0;
      pc_4_IF    <= '0;
      rvc_IF     <= 1'b0;
      predict_IF <= 1'b0;
      valid_IF   <= 1'b0;
    end else if (flush_IF) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fetch_pc <= {pc_nxt_EX[31:2], 2'b00};
      r_skip_lo  <= pc_nxt_EX[1];
      r_pc_head  <= pc_nxt_EX;
      ir_IF      <= c_NOP;
      pc_IF      <= '0;
      pc_4_IF    <= '0;
      rvc_IF     <= 1'b0;
      predict_IF <= 1'b0;
      valid_IF   <= 1'b0;
    end else begin
      // Issue register: load instruction or bubble unless stalled.
      if (!stall_IF) begin
        if (w_avail) begin
          ir_IF      <= w_rvc ? {16'h0000, w_h0} : {w_h1, w_h0};
          pc_IF      <= r_pc_head;
          pc_4_IF    <= r_pc_head + w_ilen;
          rvc_IF     <= w_rvc;
          predict_IF <= predict;
          valid_IF   <= 1'b1;
        end else begin
          ir_IF      <= c_NOP;
          pc_IF      <= '0;
          pc_4_IF    <= '0;
          rvc_IF     <= 1'b0;
          predict_IF <= 1'b0;
          valid_IF   <= 1'b0;
        end
      end

      if (w_redirect) begin
        // Everything fetched past the predicted branch is wrong-path.
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_fetch_pc <= {predict_pc[31:2], 2'b00};
        r_skip_lo  <= predict_pc[1];
        r_pc_head  <= predict_pc;
      end else begin
        if (w_can_push) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_skip_lo  <= 1'b0;
        end
        r_tail  <= r_tail + w_pushed[c_PW-1:0];
        r_head  <= r_head + w_popped[c_PW-1:0];
        r_count <= r_count + w_pushed - w_popped;
        if (w_issue) begin
          r_pc_head <= r_pc_head + w_ilen;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Purpose  : Randomized scoreboard bench for if_fetch_queue. The stimulus
//            process records each cycle's control inputs; the monitor walks
//            an instruction-stream model (program order over a random memory
//            image, with predicted-taken and flush redirects) and compares
//            every issue-register value the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

  localparam logic [31:0] c_RPC   = 32'h3000;
  localparam int          c_DEPTH = 8;
  localparam int          c_AW    = 8;
  localparam int          c_CYC   = 3000;

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush_IF;
  logic              stall_IF;
  logic [31:0]       pc_nxt_EX;
  logic              predict;
  logic [31:0]       predict_pc;
  logic [c_AW-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       pc_head;
  logic [31:0]       ir_IF;
  logic [31:0]       pc_IF;
  logic [31:0]       pc_4_IF;
  logic              rvc_IF;
  logic              predict_IF;
  logic              valid_IF;
  logic [3:0]        q_count;

  if_fetch_queue #(.RESET_PC(c_RPC), .DEPTH(c_DEPTH), .IMEM_AW(c_AW)) dut (
    .clk(clk), .rstn(rstn), .flush_IF(flush_IF), .stall_IF(stall_IF),
    .pc_nxt_EX(pc_nxt_EX), .predict(predict), .predict_pc(predict_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_head(pc_head),
    .ir_IF(ir_IF), .pc_IF(pc_IF), .pc_4_IF(pc_4_IF), .rvc_IF(rvc_IF),
    .predict_IF(predict_IF), .valid_IF(valid_IF), .q_count(q_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  assign imem_rdata = mem[imem_addr];

  // Predictor stand-in: taken at a fixed set of PCs, fixed offset target.
  function automatic logic is_pred(input logic [31:0] pc);
    return pc[5:0] == 6'd14;
  endfunction
  function automatic logic [31:0] tgt(input logic [31:0] pc);
    return pc + 32'h126;
  endfunction
  assign predict    = is_pred(pc_head);
  assign predict_pc = tgt(pc_head);

  function automatic logic [15:0] hw(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[9:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        stall;
    logic [31:0] target;
  } rec_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        rvc;
    logic        pred;
    logic        valid;
  } out_t;

  function automatic out_t bubble();
    out_t b;
    b       = '0;
    b.ir    = 32'h13;
    return b;
  endfunction

  rec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_out(input out_t e);
    chk("ir_IF", ir_IF, e.ir);
    chk("pc_IF", pc_IF, e.pc);
    chk("pc_4_IF", pc_4_IF, e.pc4);
    chk("rvc/pred/valid", {29'b0, rvc_IF, predict_IF, valid_IF},
        {29'b0, e.rvc, e.pred, e.valid});
  endtask

  // Monitor / reference model: program-order instruction stream.
  initial begin
    rec_t        r;
    out_t        e;
    out_t        last;
    logic [31:0] exp_pc;
    logic [15:0] h0;
    int          stall_run;
    int          bub_run;
    exp_pc    = c_RPC;
    last      = bubble();
    stall_run = 0;
    bub_run   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on && sb.size() > 0) begin
        r = sb.pop_front();
        if (r.rst) begin
          last = bubble(); exp_pc = c_RPC; stall_run = 0; bub_run = 0;
          cmp_out(last);
          chk("q_count_rst", 32'(q_count), 32'd0);
        end else if (r.flush) begin
          last = bubble(); exp_pc = r.target; stall_run = 0; bub_run = 0;
          cmp_out(last);
          chk("q_count_flush", 32'(q_count), 32'd0);
          chk("pc_head_flush", pc_head, r.target);
        end else if (r.stall) begin
          cmp_out(last);
          stall_run++;
          if (stall_run >= 5)
            chk("q_full_stall", 32'(q_count >= 4'(c_DEPTH - 1)), 32'd1);
        end else begin
          stall_run = 0;
          if (!valid_IF) begin
            last = bubble();
            cmp_out(last);
            bub_run++;
            chk("bubble_run", 32'(bub_run > 8), 32'd0);
          end else begin
            bub_run = 0;
            h0      = hw(exp_pc);
            e.rvc   = (h0[1:0] != 2'b11);
            e.ir    = e.rvc ? {16'h0, h0} : {hw(exp_pc + 32'd2), h0};
            e.pc    = exp_pc;
            e.pc4   = exp_pc + (e.rvc ? 32'd2 : 32'd4);
            e.pred  = is_pred(exp_pc);
            e.valid = 1'b1;
            cmp_out(e);
            last   = e;
            exp_pc = e.pred ? tgt(exp_pc) : e.pc4;
          end
        end
      end
    end
  end

  task automatic check_reset_state();
    chk("rst_valid", 32'(valid_IF), 32'd0);
    chk("rst_ir", ir_IF, 32'h13);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_pc_head", pc_head, c_RPC);
    chk("rst_imem_addr", 32'(imem_addr), 32'(c_RPC[9:2]));
  endtask

  // Stimulus
  initial begin
    rec_t r;
    int   stall_left;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h00A0_0093;
    mem[1] = 32'h00B0_0113;
    rstn = 1'b0; flush_IF = 1'b0; stall_IF = 1'b0; pc_nxt_EX = '0;
    stall_left = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state();
    for (int c = 0; c < c_CYC; c++) begin
      @(negedge clk);
      r = '0;
      if (c == c_CYC / 2 || c == c_CYC / 2 + 1) begin
        rstn = 1'b0; flush_IF = 1'b0; stall_IF = 1'b0;
        r.rst = 1'b1;
        sb.push_back(r);
        mon_on = 1'b1;
        if (c == c_CYC / 2) begin
          #1;
          check_reset_state();
        end
        continue;
      end
      rstn = 1'b1;
      r.flush  = ($urandom_range(0, 24) == 0);
      r.target = c_RPC + 32'($urandom_range(0, 511)) * 32'd2;
      if (stall_left > 0) begin
        r.stall = 1'b1;
        stall_left--;
      end else if ($urandom_range(0, 40) == 0) begin
        r.stall    = 1'b1;
        stall_left = 5;
      end else begin
        r.stall = ($urandom_range(0, 5) == 0);
      end
      flush_IF  = r.flush;
      stall_IF  = r.stall;
      pc_nxt_EX = r.target;
      sb.push_back(r);
      mon_on = 1'b1;
    end
    @(negedge clk);
    flush_IF = 1'b0; stall_IF = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
